// File: rtl/parking_display_pkg.sv
// -----------------------------------------------------------------------------
// parking_display_pkg
// Shared definitions for the free-slot display scan controller.
//   state_t    : conversion FSM states (IDLE, CONVERT, UPDATE)
//   NUM_DIGITS : number of decimal digits shown (units, tens, hundreds)
//   BCD_W      : width of one BCD digit
//   BIN_W      : width of the binary count being displayed
// -----------------------------------------------------------------------------
package parking_display_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = 4;
    localparam int BIN_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_step.sv
// -----------------------------------------------------------------------------
// bin2bcd_step
// One combinational double-dabble iteration: add 3 to every BCD digit that is
// 5 or more, then shift {bcd, bin} left by one bit.
// Ports:
//   i_bcd [10:0] : BCD scratch before the iteration (MSB omitted, see below)
//   i_bin [7:0]  : remaining binary bits, MSB is shifted into the BCD units
//   o_bcd [11:0] : BCD scratch after the iteration
//   o_bin [7:0]  : binary bits after the shift
// The hundreds digit only ever receives carries from the tens digit. With an
// 8-bit input it stays at 0 or 1 before the final shift, so it never needs
// the add-3 correction and its top bit is always 0 on entry.
// -----------------------------------------------------------------------------
import parking_display_pkg::*;

module bin2bcd_step (
    input  logic [NUM_DIGITS*BCD_W-2:0] i_bcd,
    input  logic [BIN_W-1:0]            i_bin,
    output logic [NUM_DIGITS*BCD_W-1:0] o_bcd,
    output logic [BIN_W-1:0]            o_bin
);

    logic [(NUM_DIGITS-1)*BCD_W-1:0] w_adj;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_adj
            assign w_adj[gi*BCD_W +: BCD_W] =
                (i_bcd[gi*BCD_W +: BCD_W] >= 4'd5) ? i_bcd[gi*BCD_W +: BCD_W] + 4'd3
                                                   : i_bcd[gi*BCD_W +: BCD_W];
        end
    endgenerate

    assign o_bcd = {i_bcd[NUM_DIGITS*BCD_W-2:(NUM_DIGITS-1)*BCD_W], w_adj, i_bin[BIN_W-1]};
    assign o_bin = {i_bin[BIN_W-2:0], 1'b0};

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Converts an 8-bit free-slot count to BCD (one double-dabble step per clock)
// and time-multiplexes the three digits onto a shared 7-segment decoder.
// Parameters:
//   REFRESH_DIV      : clock cycles each digit stays selected (>= 2)
//   DIGIT_ACTIVE_LOW : 1 = selected digit line driven low
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst_n      : synchronous active-low reset
//   i_count[7:0] : binary count to display
//   i_load       : one-cycle request to latch i_count and convert it
//   o_busy       : conversion in progress; i_load ignored while high
//   o_bcd[3:0]   : BCD digit of the currently selected position
//   o_digit_sel  : one-hot digit enable (bit0 units, bit1 tens, bit2 hundreds)
// Build option: define LEADING_ZERO_BLANK_EN to blank leading-zero digits.
// -----------------------------------------------------------------------------
import parking_display_pkg::*;

module display_scan_controller #(
    parameter int REFRESH_DIV      = 50000,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [BIN_W-1:0] i_count,
    input  logic             i_load,
    output logic             o_busy,
    output logic [BCD_W-1:0] o_bcd,
    output logic [2:0]       o_digit_sel
);

    localparam int                CNT_W        = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam int                BCD_ALL_W    = NUM_DIGITS * BCD_W;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_accept;
    logic [BIN_W-1:0]       r_shift;
    logic [BCD_ALL_W-1:0]   r_scratch;
    logic [BCD_ALL_W-1:0]   r_display;
    logic [2:0]             r_iter;
    logic [BCD_ALL_W-1:0]   w_step_bcd;
    logic [BIN_W-1:0]       w_step_bin;

    logic [CNT_W-1:0]       r_refresh;
    logic [1:0]             r_index;
    logic                   w_wrap;
    logic [1:0]             w_index_next;
    logic [BCD_ALL_W-1:0]   w_display_next;
    logic [2:0]             w_onehot;
    logic                   w_blank;
    logic [2:0]             w_sel_next;
    logic [BCD_W-1:0]       r_bcd;
    logic [2:0]             r_sel;

    bin2bcd_step u_step (
        .i_bcd (r_scratch[BCD_ALL_W-2:0]),
        .i_bin (r_shift),
        .o_bcd (w_step_bcd),
        .o_bin (w_step_bin)
    );

    // ---------------- conversion FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_accept     = 1'b1;
                    w_state_next = CONVERT;
                end
            end
            CONVERT: if (r_iter == 3'd7) w_state_next = UPDATE;
            UPDATE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign o_busy = (r_state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_iter    <= '0;
            r_display <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= i_count;
                        r_scratch <= '0;
                        r_iter    <= '0;
                    end
                end
                CONVERT: begin
                    r_shift   <= w_step_bin;
                    r_scratch <= w_step_bcd;
                    r_iter    <= r_iter + 3'd1;
                end
                UPDATE:  r_display <= r_scratch;
                default: ;
            endcase
        end
    end

    // ---------------- digit scanning ----------------
    // Outputs are registered from the next-cycle display/index so o_bcd and
    // o_digit_sel always move together and track the display register update
    // on the same edge.
    assign w_wrap         = (r_refresh == REFRESH_LAST);
    assign w_index_next   = !w_wrap ? r_index
                          : (r_index == 2'(NUM_DIGITS - 1)) ? 2'd0 : r_index + 2'd1;
    assign w_display_next = (r_state == UPDATE) ? r_scratch : r_display;
    assign w_onehot       = 3'b001 << w_index_next;

`ifdef LEADING_ZERO_BLANK_EN
    // Hundreds blanked when zero; tens blanked when tens and hundreds are zero.
    assign w_blank = ((w_index_next == 2'd2) && (w_display_next[11:8] == 4'd0)) ||
                     ((w_index_next == 2'd1) && (w_display_next[11:4] == 8'd0));
`else
    assign w_blank = 1'b0;
`endif

    assign w_sel_next = DIGIT_ACTIVE_LOW ? ~(w_blank ? 3'b000 : w_onehot)
                                         :  (w_blank ? 3'b000 : w_onehot);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_refresh <= '0;
            r_index   <= '0;
            r_bcd     <= '0;
            r_sel     <= DIGIT_ACTIVE_LOW ? 3'b110 : 3'b001;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + CNT_W'(1);
            r_index   <= w_index_next;
            r_bcd     <= w_display_next[w_index_next*BCD_W +: BCD_W];
            r_sel     <= w_sel_next;
        end
    end

    assign o_bcd       = r_bcd;
    assign o_digit_sel = r_sel;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
// Directed and randomized stimulus against a value-level reference model:
// the display is held as an integer, digits derived with / and %, and the
// conversion is modelled as a 9-cycle busy window ending in the display update.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

    localparam int DIV = 4;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] i_count = 8'd0;
    logic       i_load  = 1'b0;
    logic       o_busy;
    logic [3:0] o_bcd;
    logic [2:0] o_digit_sel;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int m_disp     = 0;
    int m_latched  = 0;
    int m_busy_cnt = 0;
    int m_ref      = 0;
    int m_idx      = 0;

    always #5 i_clk = ~i_clk;

    display_scan_controller #(
        .REFRESH_DIV      (DIV),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_count     (i_count),
        .i_load      (i_load),
        .o_busy      (o_busy),
        .o_bcd       (o_bcd),
        .o_digit_sel (o_digit_sel)
    );

    function automatic int digit_of(input int v, input int k);
        if (k == 0)      return v % 10;
        else if (k == 1) return (v / 10) % 10;
        else             return v / 100;
    endfunction

    // Digit as it should appear during its slot; 4'hF stands for "never enabled".
    function automatic logic [3:0] shown(input int v, input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k == 2 && v < 100) return 4'hF;
        if (k == 1 && v < 10)  return 4'hF;
`endif
        return 4'(digit_of(v, k));
    endfunction

    task automatic tick();
        logic [2:0] exp_sel;
        logic [3:0] exp_bcd;
        @(posedge i_clk);
        if (!i_rst_n) begin
            m_disp = 0; m_busy_cnt = 0; m_ref = 0; m_idx = 0;
        end else begin
            if (m_busy_cnt > 0) begin
                m_busy_cnt--;
                if (m_busy_cnt == 0) m_disp = m_latched;
            end else if (i_load) begin
                m_latched  = int'(i_count);
                m_busy_cnt = 9;
            end
            if (m_ref == DIV - 1) begin
                m_ref = 0;
                m_idx = (m_idx + 1) % 3;
            end else begin
                m_ref++;
            end
        end
        @(negedge i_clk);
        exp_bcd = 4'(digit_of(m_disp, m_idx));
        exp_sel = (shown(m_disp, m_idx) == 4'hF) ? 3'b111 : ~(3'b001 << m_idx);

        n_assert++;
        assert (o_busy === (m_busy_cnt > 0)) else begin
            n_fail++;
            $error("FAIL busy: observed %0b expected %0b", o_busy, (m_busy_cnt > 0));
        end
        n_assert++;
        assert (o_bcd === exp_bcd) else begin
            n_fail++;
            $error("FAIL bcd: observed %0d expected %0d (display %0d, index %0d)",
                   o_bcd, exp_bcd, m_disp, m_idx);
        end
        n_assert++;
        assert (o_digit_sel === exp_sel) else begin
            n_fail++;
            $error("FAIL digit_sel: observed %b expected %b (index %0d)",
                   o_digit_sel, exp_sel, m_idx);
        end
        $display("cycle: load=%0b count=%0d busy=%0b bcd=%0d sel=%b", i_load, i_count,
                 o_busy, o_bcd, o_digit_sel);
    endtask

    task automatic load(input logic [7:0] v);
        i_count = v;
        i_load  = 1'b1;
        tick();
        i_load  = 1'b0;
    endtask

    // Watch a full scan rotation and check each slot against the decimal value.
    task automatic scan_expect(input int v);
        logic [3:0] seen [3];
        for (int k = 0; k < 3; k++) seen[k] = 4'hF;
        repeat (3 * DIV + 1) begin
            tick();
            for (int k = 0; k < 3; k++)
                if (o_digit_sel === ~(3'b001 << k)) seen[k] = o_bcd;
        end
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            assert (seen[k] === shown(v, k)) else begin
                n_fail++;
                $error("FAIL scan_digit%0d: observed %0d expected %0d (value %0d)",
                       k, seen[k], shown(v, k), v);
            end
        end
    endtask

    initial begin
        int busy_cycles;
        int gap;

        // reset
        i_rst_n = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // 173: busy exactly 9 cycles, then 3,7,1
        load(8'd173);
        busy_cycles = o_busy ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_busy) busy_cycles++;
            else break;
        end
        n_assert++;
        assert (busy_cycles === 9) else begin
            n_fail++;
            $error("FAIL busy_len: observed %0d expected 9", busy_cycles);
        end
        scan_expect(173);

        // zero value
        load(8'd0);
        repeat (10) tick();
        scan_expect(0);

        // second load during conversion is dropped
        load(8'd255);
        repeat (2) tick();
        load(8'd9);
        repeat (10) tick();
        scan_expect(255);

        // reset in the middle of a conversion
        load(8'd42);
        repeat (4) tick();
        i_rst_n = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        scan_expect(0);
        repeat (12) tick();
        scan_expect(0);

        // atomic display change 100 -> 7
        load(8'd100);
        repeat (10) tick();
        scan_expect(100);
        load(8'd7);
        repeat (10) tick();
        scan_expect(7);

        // randomized loads, including pulses that land during conversion
        for (int r = 0; r < 30; r++) begin
            load(8'($urandom_range(0, 255)));
            gap = $urandom_range(0, 14);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) load(8'($urandom_range(0, 255)));
                else tick();
            end
        end
        repeat (12) tick();
        scan_expect(m_disp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
